// File: rtl/cfs_md_segmenter.sv
// Byte-serial to MD transfer packer: collects packet bytes into lanes starting at a
// configurable lane and presents each filled (or packet-terminated) word as one MD transfer.
module cfs_md_segmenter #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 16,
  localparam int B              = ALGN_DATA_WIDTH / 8,
  localparam int OFFSET_WIDTH   = (B == 1) ? 1 : $clog2(B),
  localparam int SIZE_WIDTH     = $clog2(B) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [OFFSET_WIDTH-1:0]    cfg_offset,
  output logic                       md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  output logic [OFFSET_WIDTH-1:0]    md_rx_offset,
  output logic [SIZE_WIDTH-1:0]      md_rx_size,
  input  logic                       md_rx_ready,
  input  logic                       md_rx_err,
  output logic [CNT_WIDTH-1:0]       cnt_xfer,
  output logic [CNT_WIDTH-1:0]       cnt_err,
  output logic                       busy
);

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_SEND    = 1'b1;

  localparam logic [OFFSET_WIDTH-1:0] LAST_LANE = OFFSET_WIDTH'(B - 1);

  logic                       r_state;
  logic [ALGN_DATA_WIDTH-1:0] r_data;
  logic [SIZE_WIDTH-1:0]      r_cnt;
  logic [OFFSET_WIDTH-1:0]    r_lane;
  logic [OFFSET_WIDTH-1:0]    r_start;
  logic                       r_sop;
  logic                       r_eop;
  logic [CNT_WIDTH-1:0]       r_cnt_xfer;
  logic [CNT_WIDTH-1:0]       r_cnt_err;

  logic                    w_accept;
  logic                    w_hs;
  logic                    w_full;
  logic [OFFSET_WIDTH-1:0] w_lane;

  // With a single lane every byte lands in lane 0 regardless of cfg_offset.
  assign w_lane   = (B == 1) ? '0 : (r_sop ? cfg_offset : r_lane);
  assign w_full   = (w_lane == LAST_LANE);
  assign w_accept = in_valid && (r_state == ST_COLLECT);
  assign w_hs     = (r_state == ST_SEND) && md_rx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_COLLECT;
      r_data     <= '0;
      r_cnt      <= '0;
      r_lane     <= '0;
      r_start    <= '0;
      r_sop      <= 1'b1;
      r_eop      <= 1'b0;
      r_cnt_xfer <= '0;
      r_cnt_err  <= '0;
    end else begin
      if (w_accept) begin
        r_data[8*w_lane +: 8] <= in_data;
        r_lane                <= w_lane + 1'b1;
        r_cnt                 <= r_cnt + 1'b1;
        r_sop                 <= 1'b0;
        if (r_sop) r_start <= w_lane;
        if (w_full || in_last) begin
          r_state <= ST_SEND;
          r_eop   <= in_last;
        end
      end
      if (w_hs) begin
        r_state <= ST_COLLECT;
        r_data  <= '0;
        r_cnt   <= '0;
        r_lane  <= '0;
        r_start <= '0;
        // A packet end forces the next byte to re-sample cfg_offset.
        r_sop   <= r_eop;
        if (r_cnt_xfer != '1) r_cnt_xfer <= r_cnt_xfer + 1'b1;
        if (md_rx_err && (r_cnt_err != '1)) r_cnt_err <= r_cnt_err + 1'b1;
      end
    end
  end

  assign in_ready     = (r_state == ST_COLLECT);
  assign md_rx_valid  = (r_state == ST_SEND);
  assign md_rx_data   = r_data;
  assign md_rx_offset = r_start;
  assign md_rx_size   = r_cnt;
  assign cnt_xfer     = r_cnt_xfer;
  assign cnt_err      = r_cnt_err;
  assign busy         = (r_state == ST_SEND) || !r_sop;

endmodule
